// File: rtl/hazard_pkg.sv
// Shared types for the hazard control slice.
//   fwd_sel_e  : Execute operand source select (register file / WB / MEM).
//   hz_state_e : data-memory wait FSM states.
//   wb_src_t   : a write-back source (enable + destination register).
//   satInc     : saturating increment for the event counters.
package hazard_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN  = 2'b00,
    WAIT = 2'b01,
    ERR  = 2'b10
  } hz_state_e;

  typedef struct packed {
    logic       regWEn;
    logic [4:0] rd;
  } wb_src_t;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/hz_forward_sel.sv
// Operand forwarding select for one Execute source register.
//   rs   : Execute-stage source register
//   srcM : Memory-stage write-back source
//   srcW : Writeback-stage write-back source
//   sel  : FWD_MEM, FWD_WB or FWD_RF; Memory wins because it is younger.
module hz_forward_sel
  import hazard_pkg::*;
(
  input  logic [4:0] rs,
  input  wb_src_t    srcM,
  input  wb_src_t    srcW,
  output fwd_sel_e   sel
);

  logic hitM, hitW;

  // x0 is hard-wired zero, so a write to it never forwards.
  assign hitM = srcM.regWEn && (srcM.rd != 5'd0) && (srcM.rd == rs);
  assign hitW = srcW.regWEn && (srcW.rd != 5'd0) && (srcW.rd == rs);

  always_comb begin
    sel = FWD_RF;
    if (hitW) sel = FWD_WB;
    if (hitM) sel = FWD_MEM;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use bubble, branch flush,
// data-memory wait freeze with timeout, and saturating event counters.
//   clk, reset              : clock, asynchronous active-high reset
//   rs1D/rs2D               : Decode sources
//   rs1E/rs2E/rdE, MemReadE : Execute sources/destination, load flag
//   PCSrcE                  : taken branch/jump resolved in Execute
//   RegWEnM/rdM, RegWEnW/rdW: write-back sources in Memory/Writeback
//   MemAccessM, dmem_ready  : Memory-stage access and its completion
//   Stall*/Flush*           : pipeline register holds / clears
//   ForwardAE/ForwardBE     : Execute operand selects (fwd_sel_e encoding)
//   mem_err                 : high while the FSM sits in ERR
//   lu_cnt/flush_cnt        : saturating load-use / branch-flush counts
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned WAIT_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  input  logic [4:0]       rs1E,
  input  logic [4:0]       rs2E,
  input  logic [4:0]       rdE,
  input  logic             MemReadE,
  input  logic             PCSrcE,
  input  logic             RegWEnM,
  input  logic             RegWEnW,
  input  logic [4:0]       rdM,
  input  logic [4:0]       rdW,
  input  logic             MemAccessM,
  input  logic             dmem_ready,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             StallW,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             mem_err,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(WAIT_TIMEOUT);

  // ---------------- forwarding: one selector per Execute operand
  wb_src_t          srcM, srcW;
  logic [1:0][4:0]  rsE;
  fwd_sel_e [1:0]   fwdSel;

  assign srcM = '{regWEn: RegWEnM, rd: rdM};
  assign srcW = '{regWEn: RegWEnW, rd: rdW};
  assign rsE  = {rs2E, rs1E};

  for (genvar i = 0; i < 2; i++) begin : g_fwd
    hz_forward_sel u_sel (
      .rs  (rsE[i]),
      .srcM(srcM),
      .srcW(srcW),
      .sel (fwdSel[i])
    );
  end

  assign ForwardAE = reset ? FWD_RF : fwdSel[0];
  assign ForwardBE = reset ? FWD_RF : fwdSel[1];

  // ---------------- hazard detection
  hz_state_e        state, stateNxt;
  logic [CNT_W-1:0] waitCnt, waitNxt;
  logic             memStall, loadUse, frozen, branchFlush, luBubble;

  assign memStall = MemAccessM & ~dmem_ready;
  assign loadUse  = MemReadE && (rdE != 5'd0) && ((rdE == rs1D) || (rdE == rs2D));

  // Frozen pipeline outranks everything; a branch flush kills the
  // Decode instruction, so a coincident load-use needs no bubble.
  assign frozen      = (state == ERR) | memStall;
  assign branchFlush = ~frozen & PCSrcE;
  assign luBubble    = ~frozen & ~PCSrcE & loadUse;

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    StallW = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    if (reset) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (frozen) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      StallW = 1'b1;
    end else if (branchFlush) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (luBubble) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  assign mem_err = (state == ERR);

  // ---------------- data-memory wait FSM
  // The cycle that enters WAIT is already wait cycle 1. WAIT is left as
  // soon as the pipeline is no longer held by the memory stage.
  always_comb begin
    stateNxt = state;
    waitNxt  = waitCnt;
    case (state)
      RUN: begin
        if (memStall) begin
          waitNxt  = CNT_W'(1);
          stateNxt = (TIMEOUT <= CNT_W'(1)) ? ERR : WAIT;
        end
      end
      WAIT: begin
        if (memStall) begin
          waitNxt = waitCnt + 1'b1;
          if (waitNxt >= TIMEOUT) stateNxt = ERR;
        end else begin
          stateNxt = RUN;
        end
      end
      ERR:     stateNxt = ERR;
      default: stateNxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      waitCnt   <= '0;
      lu_cnt    <= '0;
      flush_cnt <= '0;
    end else begin
      state   <= stateNxt;
      waitCnt <= waitNxt;
      if (luBubble)    lu_cnt    <= satInc(lu_cnt);
      if (branchFlush) flush_cnt <= satInc(flush_cnt);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a spec-level model checked every
// negedge, plus hand-computed literal checks at key points.
module tb_hazard_ctrl;

  localparam int TO = 4;

  logic       clk = 1'b0, reset = 1'b1;
  logic [4:0] rs1D = 0, rs2D = 0, rs1E = 0, rs2E = 0, rdE = 0, rdM = 0, rdW = 0;
  logic       MemReadE = 0, PCSrcE = 0, RegWEnM = 0, RegWEnW = 0;
  logic       MemAccessM = 0, dmem_ready = 0;
  logic       StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, mem_err;
  logic [1:0] ForwardAE, ForwardBE;
  logic [15:0] lu_cnt, flush_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.WAIT_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
    .MemReadE(MemReadE), .PCSrcE(PCSrcE),
    .RegWEnM(RegWEnM), .RegWEnW(RegWEnW), .rdM(rdM), .rdW(rdW),
    .MemAccessM(MemAccessM), .dmem_ready(dmem_ready),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
    .FlushD(FlushD), .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .mem_err(mem_err), .lu_cnt(lu_cnt), .flush_cnt(flush_cnt)
  );

  int nCmp = 0, nErr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model
  int mSt = 0;     // 0 run, 1 waiting on memory, 2 error
  int mWait = 0;   // wait cycles spent so far
  int mLu = 0, mFl = 0;
  logic mStall, lUse;

  assign mStall = MemAccessM && !dmem_ready;
  assign lUse   = MemReadE && rdE != 0 && (rdE == rs1D || rdE == rs2D);

  function automatic logic [1:0] fwdExp(input logic [4:0] rs);
    if (RegWEnM && rdM != 0 && rdM == rs) return 2'b10;
    if (RegWEnW && rdW != 0 && rdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mSt <= 0; mWait <= 0; mLu <= 0; mFl <= 0;
    end else if (mSt != 2) begin
      if (mStall) begin
        mWait <= (mSt == 0) ? 1 : mWait + 1;
        mSt   <= (((mSt == 0) ? 1 : mWait + 1) >= TO) ? 2 : 1;
      end else begin
        mSt <= 0;
        if (PCSrcE)    mFl <= (mFl < 65535) ? mFl + 1 : mFl;
        else if (lUse) mLu <= (mLu < 65535) ? mLu + 1 : mLu;
      end
    end
  end

  always @(negedge clk) begin : cmpBlk
    logic [4:0] eS;
    logic [1:0] eFl, eA, eB;
    eS = 5'b0; eFl = 2'b0;
    eA = reset ? 2'b00 : fwdExp(rs1E);
    eB = reset ? 2'b00 : fwdExp(rs2E);
    if (reset)                     eFl = 2'b11;
    else if (mSt == 2 || mStall)   eS  = 5'b11111;
    else if (PCSrcE)               eFl = 2'b11;
    else if (lUse) begin           eS  = 5'b11000; eFl = 2'b01; end
    chk("ctl", {24'b0, StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, mem_err},
               {24'b0, eS, eFl, (mSt == 2)});
    chk("fwd", {28'b0, ForwardAE, ForwardBE}, {28'b0, eA, eB});
    chk("cnt", {lu_cnt, flush_cnt}, {mLu[15:0], mFl[15:0]});
  end

  // ---------------- directed stimulus
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
    MemReadE = 0; PCSrcE = 0; RegWEnM = 0; RegWEnW = 0;
    MemAccessM = 0; dmem_ready = 0;
  endtask

  task automatic setv(input logic [4:0] a1D, a2D, a1E, a2E, aRdE, input logic lr,
                      input logic br, input logic [4:0] aRdM, input logic wm,
                      input logic [4:0] aRdW, input logic ww);
    rs1D = a1D; rs2D = a2D; rs1E = a1E; rs2E = a2E; rdE = aRdE; MemReadE = lr;
    PCSrcE = br; rdM = aRdM; RegWEnM = wm; rdW = aRdW; RegWEnW = ww;
    MemAccessM = 0; dmem_ready = 0;
    tick();
  endtask

  initial begin
    // reset overrides hazards and forwarding
    MemAccessM = 1; PCSrcE = 1; RegWEnM = 1; rdM = 5; rs1E = 5;
    #2;
    chk("rst_StallF", StallF, 0);
    chk("rst_FlushD", FlushD, 1);
    chk("rst_FlushE", FlushE, 1);
    chk("rst_FwdA", ForwardAE, 0);
    chk("rst_memerr", mem_err, 0);
    chk("rst_lucnt", lu_cnt, 0);
    tick(); tick();
    reset = 0; idle();

    // forwarding: Memory over Writeback, x0 never forwards
    RegWEnM = 1; rdM = 5; RegWEnW = 1; rdW = 5; rs1E = 5; #1;
    chk("fwd_mem", ForwardAE, 2'b10);
    rdM = 0; #1;
    chk("fwd_wb", ForwardAE, 2'b01);
    tick();
    rs2E = 9; rdW = 9; rdM = 9; RegWEnM = 0; #1;
    chk("fwdB_wb", ForwardBE, 2'b01);
    tick();
    rs1E = 0; rdW = 0; RegWEnM = 1; rdM = 0; #1;
    chk("fwd_x0", ForwardAE, 2'b00);
    tick(); idle();

    // load-use bubble
    MemReadE = 1; rdE = 7; rs2D = 7; #1;
    chk("lu_StallF", StallF, 1);
    chk("lu_StallD", StallD, 1);
    chk("lu_FlushE", FlushE, 1);
    chk("lu_StallE", StallE, 0);
    chk("lu_FlushD", FlushD, 0);
    tick();
    chk("lu_cnt1", lu_cnt, 1);
    MemReadE = 0; #1;
    chk("lu_done", StallF, 0);
    tick();

    // branch flush discards coincident load-use
    MemReadE = 1; rdE = 7; rs2D = 7; PCSrcE = 1; #1;
    chk("br_FlushD", FlushD, 1);
    chk("br_FlushE", FlushE, 1);
    chk("br_StallF", StallF, 0);
    tick();
    chk("br_lucnt", lu_cnt, 1);
    chk("br_flcnt", flush_cnt, 1);
    idle();

    // two 3-cycle memory waits back to back; the wait count must restart
    for (int r = 0; r < 2; r++) begin
      MemAccessM = 1; dmem_ready = 0; MemReadE = 1; rdE = 7; rs2D = 7; PCSrcE = 1;
      for (int c = 0; c < 3; c++) begin
        #1;
        chk("ms_StallW", StallW, 1);
        chk("ms_FlushD", FlushD, 0);
        tick();
      end
      MemReadE = 0; PCSrcE = 0; dmem_ready = 1; #1;
      chk("ms_release", StallF, 0);
      tick();
    end
    chk("ms_memerr", mem_err, 0);
    chk("ms_lucnt", lu_cnt, 1);
    chk("ms_flcnt", flush_cnt, 1);
    idle();

    // timeout into ERR; ERR ignores ready and branches
    MemAccessM = 1; dmem_ready = 0;
    tick(); tick(); tick();
    chk("to_before", mem_err, 0);
    tick();
    chk("to_err", mem_err, 1);
    chk("to_stall", StallF, 1);
    MemAccessM = 0; dmem_ready = 1; PCSrcE = 1; #1;
    chk("err_StallM", StallM, 1);
    chk("err_FlushD", FlushD, 0);
    tick();
    chk("err_flcnt", flush_cnt, 1);
    chk("err_stays", mem_err, 1);
    reset = 1; #1;
    chk("err_rst_memerr", mem_err, 0);
    chk("err_rst_lucnt", lu_cnt, 0);
    chk("err_rst_flcnt", flush_cnt, 0);
    chk("err_rst_StallF", StallF, 0);
    tick();
    reset = 0; idle();

    // reset mid-wait restarts the wait count
    MemAccessM = 1; dmem_ready = 0;
    tick(); tick();
    reset = 1; #1;
    chk("mw_rst_StallW", StallW, 0);
    tick();
    reset = 0;
    tick(); tick(); tick();
    chk("mw_noerr", mem_err, 0);
    dmem_ready = 1; tick();
    chk("mw_run", mem_err, 0);
    idle();

    // mixed vectors, checked by the model only
    setv(3, 4, 3, 4, 3, 1, 0, 3, 1, 4, 1);
    setv(1, 2, 6, 6, 0, 1, 0, 6, 0, 6, 1);
    setv(8, 8, 8, 2, 8, 1, 1, 2, 1, 8, 1);
    setv(5, 1, 1, 5, 9, 1, 0, 1, 1, 1, 0);
    setv(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1);
    setv(31, 30, 31, 30, 30, 1, 0, 30, 1, 31, 1);
    idle();

    // saturation of the load-use counter
    MemReadE = 1; rdE = 3; rs1D = 3;
    repeat (65540) tick();
    chk("lu_sat", lu_cnt, 16'hFFFF);
    idle(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
